// File: rtl/rf_wport_arbiter.sv
// RegFile write-port arbiter: in-order WB vs a FIFO of MUL/DIV results; RF_ARB_STARVE_GUARD_EN adds a starvation guard.
// Latency: one cycle from grant to the registered rf_we/rf_waddr/rf_wdata.
// Backpressure: ll_ready drops when the FIFO is full; guard build can stall WB for one cycle.
module rf_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wb_we,
    input  logic [4:0]             wb_addr,
    input  logic [31:0]            wb_data,
    input  logic                   ll_valid,
    output logic                   ll_ready,
    input  logic [4:0]             ll_addr,
    input  logic [31:0]            ll_data,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    input  logic [4:0]             rd_addr1,
    input  logic [4:0]             rd_addr2,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   wb_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    typedef struct packed {
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] dat;
    } ent_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_param
        $error("rf_wport_arbiter: DEPTH must be a power of 2 >= 2 and MAX_WAIT >= 1");
    end

    ent_t          ent [DEPTH];
    ent_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          wb_grant;
    logic          pop;
    logic          push;

    assign empty    = (fifo_count == '0);
    assign ll_ready = (fifo_count < DEPTH_C);
    assign head     = ent[rd_ptr];

    // r0 writes from either side are dropped; they never occupy the port or a slot
    assign wb_grant = wb_we && (wb_addr != 5'd0) && !wb_stall;
    assign pop      = !wb_grant && !empty;
    assign push     = ll_valid && ll_ready && (ll_addr != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // Buffered results are older than WB, so a WB write kills matching stale entries.
            // The push below comes later and wins, so a same-cycle push is never squashed.
            if (wb_grant) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent[i].vld && (ent[i].addr == wb_addr)) begin
                        ent[i].vld <= 1'b0;
                    end
                end
            end
            if (pop) begin
                ent[rd_ptr].vld <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent[wr_ptr] <= '{vld: 1'b1, addr: ll_addr, dat: ll_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (wb_grant) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
        end else if (pop) begin
            rf_we <= head.vld;
            if (head.vld) begin
                rf_waddr <= head.addr;
                rf_wdata <= head.dat;
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].vld && (ent[i].addr == rd_addr1)) pend1 = 1'b1;
            if (ent[i].vld && (ent[i].addr == rd_addr2)) pend2 = 1'b1;
        end
        if (rd_addr1 == 5'd0) pend1 = 1'b0;
        if (rd_addr2 == 5'd0) pend2 = 1'b0;
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] wait_cnt;

    // Stall fires on the edge the counter would reach MAX_WAIT; the stalled cycle forces a pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
            wb_stall <= 1'b0;
        end else begin
            wb_stall <= 1'b0;
            if (empty || pop) begin
                wait_cnt <= '0;
            end else if (wait_cnt == WAIT_LAST) begin
                wait_cnt <= '0;
                wb_stall <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_rf_wport_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        pend1;
    logic        pend2;
    logic        wb_stall;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2),
        .wb_stall(wb_stall), .fifo_count(fifo_count)
    );

    // Reference model: a queue of buffered results in program order plus the expected write port
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          vld;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_stall;
    int          m_wait;

    function automatic bit m_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].vld && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        m_stall = 1'b0; m_wait = 0;
    endtask

    task automatic model_edge();
        bit grant, pop, push, had_entries;
        had_entries = (mq.size() != 0);
        grant = wb_we && (wb_addr != 5'd0) && !m_stall;
        pop   = !grant && had_entries;
        push  = ll_valid && (mq.size() < DEPTH) && (ll_addr != 5'd0);
        if (grant) begin
            m_we = 1'b1; m_waddr = wb_addr; m_wdata = wb_data;
            foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].vld = 1'b0;
        end else if (pop) begin
            m_we = mq[0].vld;
            if (mq[0].vld) begin m_waddr = mq[0].addr; m_wdata = mq[0].data; end
        end else begin
            m_we = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{ll_addr, ll_data, 1'b1});
`ifdef RF_ARB_STARVE_GUARD_EN
        m_stall = 1'b0;
        if (!had_entries || pop) m_wait = 0;
        else begin
            m_wait = m_wait + 1;
            if (m_wait == MAX_WAIT) begin m_wait = 0; m_stall = 1'b1; end
        end
`endif
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        wb_we = we; wb_addr = wa; wb_data = wd;
        ll_valid = lv; ll_addr = la; ll_data = ld;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rd_addr1 = 5'd3; rd_addr2 = 5'd4;
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wfields: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        checks++; if (fifo_count !== 3'd0 || ll_ready !== 1'b1) begin errors++; $display("FAIL reset_fifo: count %0d ready %0b want 0/1", fifo_count, ll_ready); end
        checks++; if (wb_stall !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0) begin errors++; $display("FAIL reset_flags: stall %0b pend %0b%0b want 0 00", wb_stall, pend1, pend2); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd5, 32'h11);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h22) begin errors++; $display("FAIL prio_wb_first: got we%0b r%0d %h want we1 r3 22", rf_we, rf_waddr, rf_wdata); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL prio_count1: got %0d want 1", fifo_count); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin errors++; $display("FAIL prio_ll_second: got we%0b r%0d %h want we1 r5 11", rf_we, rf_waddr, rf_wdata); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL prio_count0: got %0d want 0", fifo_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'd10, 32'h1000 + 32'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
            tick();
        end
        checks++; if (fifo_count !== 3'd4 || ll_ready !== 1'b0) begin errors++; $display("FAIL full_state: count %0d ready %0b want 4/0", fifo_count, ll_ready); end
        drive(1'b1, 5'd10, 32'h1004, 1'b1, 5'd9, 32'h999);
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_no_push: count %0d want 4", fifo_count); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== 32'h100 + 32'(i) || fifo_count !== 3'(3 - i) || ll_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_drain%0d: got we%0b r%0d %h cnt%0d rdy%0b want we1 r%0d %h cnt%0d rdy1",
                         i, rf_we, rf_waddr, rf_wdata, fifo_count, ll_ready, i + 1, 32'h100 + 32'(i), 3 - i);
            end
        end
    endtask

    task automatic test_squash();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        tick();
        rd_addr1 = 5'd7;
        drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL squash_pend_before: got %0b want 1", pend1); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBB) begin errors++; $display("FAIL squash_wb: got we%0b r%0d %h want we1 r7 bb", rf_we, rf_waddr, rf_wdata); end
        checks++; if (pend1 !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL squash_after: pend %0b cnt %0d want 0/1", pend1, fifo_count); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || rf_wdata !== 32'hBB) begin errors++; $display("FAIL squash_pop: we%0b cnt%0d %h want we0 cnt0 bb", rf_we, fifo_count, rf_wdata); end
        // same-cycle push with the WB address survives the squash
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1);
        tick();
        rd_addr2 = 5'd8;
        drive(1'b1, 5'd8, 32'h2, 1'b1, 5'd8, 32'h3);
        tick();
        checks++; if (pend2 !== 1'b1 || fifo_count !== 3'd2) begin errors++; $display("FAIL squash_samecyc: pend %0b cnt %0d want 1/2", pend2, fifo_count); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL squash_old_pop: we %0b want 0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h3) begin errors++; $display("FAIL squash_new_pop: got we%0b r%0d %h want we1 r8 3", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_r0();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        tick();
        checks++; if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL r0_push: cnt %0d we %0b want 0/0", fifo_count, rf_we); end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        tick();
        drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66 || fifo_count !== 3'd0) begin errors++; $display("FAIL r0_wb_pop: got we%0b r%0d %h cnt%0d want we1 r6 66 cnt0", rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_wb_idle: we %0b want 0", rf_we); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd20, 32'h2000 + 32'(i), 1'b1, 5'(i + 1), 32'h300 + 32'(i));
            tick();
        end
        rd_addr1 = 5'd1; rd_addr2 = 5'd3;
        #1;
        checks++; if (fifo_count !== 3'd3 || rf_we !== 1'b1 || pend1 !== 1'b1 || pend2 !== 1'b1) begin errors++; $display("FAIL rstmid_pre: cnt%0d we%0b pend%0b%0b want 3 1 11", fifo_count, rf_we, pend1, pend2); end
        resetn = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || ll_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async: we%0b cnt%0d rdy%0b want 0 0 1", rf_we, fifo_count, ll_ready); end
        checks++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin errors++; $display("FAIL rstmid_pend: got %0b%0b want 00", pend1, pend2); end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
            rd_addr1 = 5'($urandom_range(0, 7));
            rd_addr2 = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (ll_ready !== (mq.size() < DEPTH) || fifo_count !== 3'(mq.size()) || pend1 !== m_pend(rd_addr1) ||
                pend2 !== m_pend(rd_addr2) || wb_stall !== m_stall) begin
                errors++;
                $display("FAIL rand_comb%0d: rdy%0b cnt%0d p%0b%0b st%0b want rdy%0b cnt%0d p%0b%0b st%0b", n, ll_ready, fifo_count,
                         pend1, pend2, wb_stall, mq.size() < DEPTH, mq.size(), m_pend(rd_addr1), m_pend(rd_addr2), m_stall);
            end
            tick();
            checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rand_port%0d: got we%0b r%0d %h want we%0b r%0d %h", n, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
    endtask

    task automatic test_guard();
        do_reset();
        drive(1'b1, 5'd13, 32'h1313, 1'b1, 5'd12, 32'h5A);
        tick();
        drive(1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'd0);
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int k = 0; k < MAX_WAIT; k++) begin
            checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL guard_early%0d: stall %0b want 0", k, wb_stall); end
            tick();
        end
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL guard_fire: stall %0b want 1", wb_stall); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h5A || wb_stall !== 1'b0) begin errors++; $display("FAIL guard_pop: got we%0b r%0d %h st%0b want we1 r12 5a st0", rf_we, rf_waddr, rf_wdata, wb_stall); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'h1313) begin errors++; $display("FAIL guard_wb_next: got we%0b r%0d %h want we1 r13 1313", rf_we, rf_waddr, rf_wdata); end
`else
        for (int k = 0; k < MAX_WAIT + 4; k++) begin
            tick();
            checks++;
            if (wb_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd13 || fifo_count !== 3'd1) begin
                errors++;
                $display("FAIL noguard_prio%0d: st%0b we%0b r%0d cnt%0d want st0 we1 r13 cnt1", k, wb_stall, rf_we, rf_waddr, fifo_count);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h5A) begin errors++; $display("FAIL noguard_drain: got we%0b r%0d %h want we1 r12 5a", rf_we, rf_waddr, rf_wdata); end
`endif
    endtask

    initial begin
        resetn = 1'b0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_priority();
        test_full();
        test_squash();
        test_r0();
        test_reset_mid();
        test_random();
        test_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
